// File: rtl/polymul_arbiter_if.sv
// Request/response and multiplier-side handshake bundle for the two-requester polynomial
// multiplier front end. The slave modport is the arbiter; master is its environment.
interface polymul_arbiter_if #(
    parameter int unsigned logq = 5
);
    logic [1:0]          req_valid;
    logic [2*logq-1:0]   req_coef0;
    logic [2*logq-1:0]   req_coef1;
    logic [1:0]          req_ready;
    logic [1:0]          resp_valid;
    logic [logq-1:0]     resp_coef;
    logic [1:0]          resp_ready;
    logic                mul_in0_valid;
    logic                mul_in1_valid;
    logic [logq-1:0]     mul_poly_in0;
    logic [logq-1:0]     mul_poly_in1;
    logic                mul_in_ready;
    logic                mul_out_valid;
    logic [logq-1:0]     mul_poly_out;
    logic                mul_out_ready;

    modport slave (
        input  req_valid, req_coef0, req_coef1, resp_ready,
        input  mul_in_ready, mul_out_valid, mul_poly_out,
        output req_ready, resp_valid, resp_coef,
        output mul_in0_valid, mul_in1_valid, mul_poly_in0, mul_poly_in1, mul_out_ready
    );

    modport master (
        output req_valid, req_coef0, req_coef1, resp_ready,
        output mul_in_ready, mul_out_valid, mul_poly_out,
        input  req_ready, resp_valid, resp_coef,
        input  mul_in0_valid, mul_in1_valid, mul_poly_in0, mul_poly_in1, mul_out_ready
    );
endinterface

// File: rtl/polymul_arbiter.sv
// Shares one coefficient-serial negacyclic multiplier between two requesters: a grant covers
// a whole job (N beats in, N beats back), jobs alternate round-robin, errors are sticky.
module polymul_arbiter #(
    parameter int unsigned q    = 17,
    parameter int unsigned N    = 8,
    parameter int unsigned logq = 5,
    parameter int unsigned logN = 3
) (
    input  logic             clk,
    input  logic             reset,
    polymul_arbiter_if.slave bus,
    output logic             busy,
    output logic             owner,
    output logic [15:0]      done_cnt0,
    output logic [15:0]      done_cnt1,
    output logic             proto_err
);
    localparam int unsigned     CNT_W     = 16;
    localparam logic [logN-1:0] LAST_BEAT = logN'(N - 1);

    // Coefficients must fit the bus and the beat counter must cover exactly N beats.
    if ((q >= (32'd1 << logq)) || (N != (32'd1 << logN))) begin : g_param_check
        $error("polymul_arbiter: inconsistent q/logq or N/logN");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RETURN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [logN-1:0]   beat_q, beat_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [CNT_W-1:0]  done0_q, done0_d;
    logic [CNT_W-1:0]  done1_q, done1_d;
    logic              err_q, err_d;

    logic [1:0]        owner_oh_c;
    logic              in_valid_c;
    logic              fire_in_c;
    logic              fire_out_c;
    logic [logq-1:0]   own_coef0_c;
    logic [logq-1:0]   own_coef1_c;

    assign owner_oh_c  = owner_q ? 2'b10 : 2'b01;
    assign own_coef0_c = owner_q ? bus.req_coef0[logq +: logq] : bus.req_coef0[0 +: logq];
    assign own_coef1_c = owner_q ? bus.req_coef1[logq +: logq] : bus.req_coef1[0 +: logq];
    // Valid toward the multiplier depends only on the owner's request, never on in_ready.
    assign in_valid_c  = (state_q == S_LOAD) && bus.req_valid[owner_q];
    assign fire_in_c   = in_valid_c && bus.mul_in_ready;
    assign fire_out_c  = (state_q == S_RETURN) && bus.mul_out_valid && bus.resp_ready[owner_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            done0_q <= '0;
            done1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        done0_d  = done0_q;
        done1_d  = done1_q;
        err_d    = err_q;

        bus.req_ready     = 2'b00;
        bus.resp_valid    = 2'b00;
        bus.resp_coef     = bus.mul_poly_out;
        bus.mul_in0_valid = 1'b0;
        bus.mul_in1_valid = 1'b0;
        bus.mul_poly_in0  = own_coef0_c;
        bus.mul_poly_in1  = own_coef1_c;
        bus.mul_out_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    owner_d = bus.req_valid[prio_q] ? prio_q : ~prio_q;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.mul_in0_valid = in_valid_c;
                bus.mul_in1_valid = in_valid_c;
                bus.req_ready     = owner_oh_c & {2{fire_in_c}};
                if (fire_in_c) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_RETURN;
                    end else begin
                        beat_d = beat_q + logN'(1);
                    end
                end
            end
            S_RETURN: begin
                bus.resp_valid    = owner_oh_c & {2{bus.mul_out_valid}};
                bus.mul_out_ready = bus.resp_ready[owner_q];
                if (fire_out_c) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        prio_d  = ~owner_q;
                        state_d = S_IDLE;
                        if (owner_q) begin
                            done1_d = done1_q + CNT_W'(1);
                        end else begin
                            done0_d = done0_q + CNT_W'(1);
                        end
                    end else begin
                        beat_d = beat_q + logN'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase

        // Results outside RETURN, or readiness with nothing offered, mean the peer misbehaved.
        if (((state_q != S_RETURN) && bus.mul_out_valid) || (bus.mul_in_ready && !in_valid_c)) begin
            err_d = 1'b1;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;
    assign done_cnt0 = done0_q;
    assign done_cnt1 = done1_q;
    assign proto_err = err_q;

endmodule
